// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard control.
// Opcodes and mul sequencer state encoding.
package mips_pkg;

  localparam logic [5:0] OP_MUL = 6'd28;
  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LW  = 6'd35;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle between the pipeline control and the hazard sequencer.
// The pipeline is the master; the sequencer is the slave.
interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_dest;
  logic             id_regwrite;
  logic             id_is_load;
  logic             id_is_mul;
  logic             mem_redirect;
  logic             hold_front;
  logic             hazard;
  logic             hold_idex;
  logic             bubble_exmem;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_dest, id_regwrite, id_is_load, id_is_mul,
    output mem_redirect,
    input  hold_front, hazard, hold_idex, bubble_exmem,
    input  flush_ifid, flush_idex, flush_exmem,
    input  mul_busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_dest, id_regwrite, id_is_load, id_is_mul,
    input  mem_redirect,
    output hold_front, hazard, hold_idex, bubble_exmem,
    output flush_ifid, flush_idex, flush_exmem,
    output mul_busy, stall_count
  );
endinterface

// File: rtl/mul_latency_counter.sv
// Down-counter timing the multi-cycle mul in EX.
// done marks the last BUSY cycle.
module mul_latency_counter #(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic done
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (load)      cnt <= 4'(MUL_LAT - 1);
    else if (dec && cnt != '0) cnt <= cnt - 4'd1;
  end

  assign done = (cnt == 4'd1);
endmodule

// File: rtl/hazard_sequencer.sv
// Load-use stall, mul sequencing and MEM-redirect flush control
// for the 5-stage pipeline.
module hazard_sequencer
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  hazard_sequencer_if.slave hs
);
  mul_state_t state_q, state_d;

  logic       ex_valid;
  logic [4:0] ex_dest;
  logic       ex_regwrite;
  logic       ex_is_load;
  logic       ex_is_mul;

  logic busy, flush, lu, hit_rs, hit_rt, start, done;
  logic hold_front, hazard, hold_idex, bubble_exmem;
  logic [CNT_W-1:0] stall_count;

  assign busy  = (state_q == BUSY);
  assign flush = hs.mem_redirect;

  assign hit_rs = hs.id_uses_rs && (hs.id_rs == ex_dest);
  assign hit_rt = hs.id_uses_rt && (hs.id_rt == ex_dest);
  assign lu = hs.id_valid && ex_valid && ex_is_load
           && ex_regwrite && (ex_dest != 5'd0)
           && (hit_rs || hit_rt);

  assign start = !flush && !busy && !lu
              && hs.id_valid && hs.id_is_mul;

  mul_latency_counter #(.MUL_LAT(MUL_LAT)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (start),
    .dec  (busy && ex_is_mul),
    .done (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Priority chain: reset, redirect, mul busy, load-use.
  always_comb begin
    state_d      = state_q;
    hold_front   = 1'b0;
    hazard       = 1'b0;
    hold_idex    = 1'b0;
    bubble_exmem = 1'b0;
    priority case (1'b1)
      rst:   state_d = IDLE;
      flush: state_d = IDLE;
      busy: begin
        hold_front   = 1'b1;
        hold_idex    = 1'b1;
        bubble_exmem = 1'b1;
        if (done) state_d = IDLE;
      end
      lu: begin
        hold_front = 1'b1;
        hazard     = 1'b1;
      end
      default: if (start) state_d = BUSY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_dest     <= '0;
      ex_regwrite <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_is_mul   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (busy) begin
      ex_valid <= ex_valid;
    end else if (lu) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid    <= hs.id_valid;
      ex_dest     <= hs.id_dest;
      ex_regwrite <= hs.id_regwrite;
      ex_is_load  <= hs.id_is_load;
      ex_is_mul   <= hs.id_is_mul;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (hold_front && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

  assign hs.hold_front   = hold_front;
  assign hs.hazard       = hazard;
  assign hs.hold_idex    = hold_idex;
  assign hs.bubble_exmem = bubble_exmem;
  assign hs.flush_ifid   = flush && !rst;
  assign hs.flush_idex   = flush && !rst;
  assign hs.flush_exmem  = flush && !rst;
  assign hs.mul_busy     = busy;
  assign hs.stall_count  = stall_count;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with MUL_LAT=4.
// Inputs change 1 time unit after posedge; outputs checked mid-cycle.
module tb_hazard_sequencer;
  import mips_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cycles;
  logic [5:0] op;

  always #5 clk = ~clk;

  hazard_sequencer_if #(.CNT_W(CNT_W)) hs ();

  hazard_sequencer #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hs  (hs.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v,
                        input logic [4:0] rs, rt, dest,
                        input logic urs, urt, rw, ld, ml);
    hs.id_valid    = v;
    hs.id_rs       = rs;
    hs.id_rt       = rt;
    hs.id_dest     = dest;
    hs.id_uses_rs  = urs;
    hs.id_uses_rt  = urt;
    hs.id_regwrite = rw;
    hs.id_is_load  = ld;
    hs.id_is_mul   = ml;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flushes();
    return {hs.flush_ifid, hs.flush_idex, hs.flush_exmem};
  endfunction

  function automatic logic [7:0] all_outs();
    return {hs.hold_front, hs.hazard, hs.hold_idex,
            hs.bubble_exmem, flushes(), hs.mul_busy};
  endfunction

  initial begin
    op = OP_MUL;
    hs.mem_redirect = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_outs", 32'(all_outs()), 0);
    check("reset_cnt", 32'(hs.stall_count), 0);
    #11 rst = 1'b0;
    tick();

    // load-use on rs
    id_set(1, 1, 0, 5, 1, 0, 1, 1, 0);
    #1 check("lw_no_hz", 32'(hs.hazard), 0);
    tick();
    id_set(1, 5, 2, 8, 1, 1, 1, 0, 0);
    #1 check("lu_hold", 32'(hs.hold_front), 1);
    check("lu_hazard", 32'(hs.hazard), 1);
    tick();
    check("lu_cnt", 32'(hs.stall_count), 1);
    check("lu_clear", 32'({hs.hold_front, hs.hazard}), 0);
    tick();

    // load into $0, then unrelated register
    id_set(1, 1, 0, 0, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 0, 0, 3, 1, 1, 1, 0, 0);
    #1 check("zero_no_stall", 32'(hs.hold_front), 0);
    tick();
    id_set(1, 1, 0, 6, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 7, 0, 7, 1, 0, 1, 0, 0);
    #1 check("other_reg", 32'(hs.hold_front), 0);
    tick();

    // load-use through rt, gated by uses_rt
    id_set(1, 1, 0, 9, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 2, 9, 4, 1, 0, 1, 0, 0);
    #1 check("rt_unused", 32'(hs.hazard), 0);
    hs.id_uses_rt = 1'b1;
    #1 check("rt_hazard", 32'(hs.hazard), 1);
    tick();
    check("rt_cnt", 32'(hs.stall_count), 2);
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // full mul
    id_set(1, 1, 2, 10, 1, 1, 1, 0, 1);
    #1 check("mul_idle", 32'(hs.mul_busy), 0);
    tick();
    id_set(1, 10, 0, 12, 1, 0, 1, 0, 0);
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      check($sformatf("mul_b%0d", i),
            32'({hs.mul_busy, hs.hold_front,
                 hs.hold_idex, hs.bubble_exmem}), 32'hf);
      tick();
    end
    check("mul_final", 32'({hs.mul_busy, hs.hold_front,
                            hs.bubble_exmem}), 0);
    check("mul_cnt", 32'(hs.stall_count), 5);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // redirect in second BUSY cycle
    id_set(1, 1, 2, 11, 1, 1, 1, 0, 1);
    tick();
    id_set(1, 3, 0, 4, 1, 0, 1, 0, 0);
    check("rd_b1", 32'(hs.mul_busy), 1);
    tick();
    hs.mem_redirect = 1'b1;
    #1 check("rd_flush", 32'(flushes()), 3'b111);
    check("rd_hold", 32'(hs.hold_front), 0);
    tick();
    hs.mem_redirect = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("rd_busy", 32'(hs.mul_busy), 0);
    check("rd_cnt", 32'(hs.stall_count), 6);
    tick();

    // load-use coinciding with redirect
    id_set(1, 1, 0, 12, 1, 0, 1, 1, 0);
    tick();
    id_set(1, 12, 0, 13, 1, 0, 1, 0, 0);
    hs.mem_redirect = 1'b1;
    #1 check("lr_flush", 32'(flushes()), 3'b111);
    check("lr_hz", 32'({hs.hazard, hs.hold_front}), 0);
    tick();
    hs.mem_redirect = 1'b0;
    #1 check("lr_cnt", 32'(hs.stall_count), 6);
    check("lr_after", 32'(hs.hazard), 0);
    tick();

    // async reset in the middle of BUSY
    id_set(1, 1, 2, 13, 1, 1, 1, 0, 1);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2 rst = 1'b1;
    #1 check("rst_outs", 32'(all_outs()), 0);
    check("rst_cnt", 32'(hs.stall_count), 0);
    #1 rst = 1'b0;
    tick();
    id_set(1, 1, 2, 14, 1, 1, 1, 0, 1);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (hs.mul_busy) busy_cycles++;
      tick();
    end
    check("rst_mul_len", 32'(busy_cycles), MUL_LAT - 1);
    check("rst_mul_cnt", 32'(hs.stall_count), MUL_LAT - 1);
    check("op_mul", 32'(op), 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
